// File: rtl/alu_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_pipe_if
//   Handshake bundle between the operand-issue stage, the ALU and the
//   writeback stage.
//
//   Issue side  : in_valid, in_ready, a, b, op, cin
//   Result side : out_valid, out_ready, result, cout, overflow, zero, set
//
//   master : the environment (drives operands, consumes results)
//   slave  : the ALU (accepts operands, produces results)
// ---------------------------------------------------------------------------
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             set;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero, set
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero, set
  );
endinterface

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//   Registered WIDTH-bit ALU: AND, OR, ADD, SUB, SLT through a ripple of
//   4-bit carry-lookahead groups, with results and flags held in a single
//   output register behind a valid/ready handshake.
//
//   Ports:
//     clk     - clock, all state updates on the rising edge
//     rst_n   - synchronous active-low reset
//     io_bus  - alu_pipe_if.slave: operand issue (in_*, a, b, op, cin)
//               and result delivery (out_*, result, cout, overflow,
//               zero, set)
//
//   Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL.
//   Any other opcode loads result 0 with zero set after one cycle.
//
//   Build option ALU_MUL_EN: when defined, an iterative shift-add
//   multiplier (op 011) is compiled in and takes WIDTH cycles. When
//   undefined, op 011 behaves as an undefined opcode.
// ---------------------------------------------------------------------------
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new op when the output register is free/draining
// MUL    | one shift-add step per cycle, WIDTH steps (ALU_MUL_EN only)
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave io_bus
);

  localparam int NGRP = WIDTH / 4;
  localparam int MSB  = WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;
`endif

  // output register
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_set;
  logic             r_out_valid;

  // handshake
  logic w_accept;
  logic w_is_mul;
  logic w_load_single;
  logic w_mul_done;
  logic w_in_ready;

  // adder
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_in;
  logic [WIDTH-1:0] w_sum;
  logic             w_c_out;
  logic             w_ovf_raw;
  logic             w_slt;

  // single-cycle result mux
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_ovf;
  logic             w_set;

  // multiplier completion values
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_cout;

  // SUB and SLT both compute a + ~b + 1.
  assign w_is_sub = (io_bus.op == OP_SUB) || (io_bus.op == OP_SLT);
  assign w_b_eff  = w_is_sub ? ~io_bus.b : io_bus.b;
  assign w_c_in   = w_is_sub ? 1'b1 : io_bus.cin;

  // Ripple of 4-bit lookahead groups: carries inside a group come straight
  // from g/p and the group-in carry; the group-out carry uses group G/P.
  always_comb begin : cla_chain
    logic       carry;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       grp_g;
    logic       grp_p;
    carry = w_c_in;
    w_sum = '0;
    g     = '0;
    p     = '0;
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      g     = io_bus.a[4*k +: 4] & w_b_eff[4*k +: 4];
      p     = io_bus.a[4*k +: 4] ^ w_b_eff[4*k +: 4];
      c[0]  = carry;
      c[1]  = g[0] | (p[0] & carry);
      c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
      c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & carry);
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
      w_sum[4*k +: 4] = p ^ c;
      carry = grp_g | (grp_p & carry);
    end
    w_c_out = carry;
  end

  assign w_ovf_raw = (io_bus.a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != io_bus.a[MSB]);
  assign w_slt     = w_sum[MSB] ^ w_ovf_raw;

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    w_set  = 1'b0;
    case (io_bus.op)
      OP_AND: w_res = io_bus.a & io_bus.b;
      OP_OR:  w_res = io_bus.a | io_bus.b;
      OP_ADD: begin
        w_res  = w_sum;
        w_cout = w_c_out;
        w_ovf  = w_ovf_raw;
      end
      OP_SUB: begin
        w_res  = w_sum;
        w_cout = w_c_out;
        w_ovf  = w_ovf_raw;
        w_set  = w_slt;
      end
      OP_SLT: begin
        w_res = {{(WIDTH-1){1'b0}}, w_slt};
        w_set = w_slt;
      end
      default: w_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  localparam int         CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic             r_hi;

  logic [WIDTH:0]   w_acc_sum;
  logic             w_step_hi;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};

  // A multiplicand bit lost off the top only matters if a later multiplier
  // bit would have added it back in, so test the multiplier after its shift.
  assign w_step_hi = w_acc_sum[WIDTH]
                   | (r_mcand[MSB] & (r_mplier[WIDTH-1:1] != '0));

  assign w_is_mul   = (io_bus.op == OP_MUL);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_mul_res  = w_acc_sum[MSB:0];
  assign w_mul_cout = r_hi | w_step_hi;
  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || io_bus.out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_hi     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_mcand  <= io_bus.a;
            r_mplier <= io_bus.b;
            r_acc    <= '0;
            r_hi     <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_sum[MSB:0];
          r_hi     <= r_hi | w_step_hi;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_mul_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_cout = 1'b0;
  assign w_in_ready = !r_out_valid || io_bus.out_ready;
`endif

  assign w_accept      = io_bus.in_valid && w_in_ready;
  assign w_load_single = w_accept && !w_is_mul;

  // A load and a consume can share an edge; the load wins and out_valid
  // stays high so back-to-back ops flow at one per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_set       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load_single) begin
      r_result    <= w_res;
      r_cout      <= w_cout;
      r_overflow  <= w_ovf;
      r_zero      <= (w_res == '0);
      r_set       <= w_set;
      r_out_valid <= 1'b1;
    end else if (w_mul_done) begin
      r_result    <= w_mul_res;
      r_cout      <= w_mul_cout;
      r_overflow  <= 1'b0;
      r_zero      <= (w_mul_res == '0);
      r_set       <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (io_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.result    = r_result;
  assign io_bus.cout      = r_cout;
  assign io_bus.overflow  = r_overflow;
  assign io_bus.zero      = r_zero;
  assign io_bus.set       = r_set;

endmodule
